cpu_run_controller: RTL
=======================

# cpu_run_controller

Synthesizable run controller that sits beside the 5-stage `datapath` and drives its reset. It releases the core on `start`, then watches the core's debug outputs. It counts cycles and retired non-NOP instructions and decides when the program has ended, either by a halt loop of 1–4 instructions or by a timeout. On completion it freezes the core in reset and latches result, final PC and counters for an SoC register reader.

## Interface
- `RESET_CYCLES`, 2: cycles `core_reset` is held after `start` before RUN.
- `TIMEOUT_CYCLES`, 2000: RUN cycles before forced stop.
- `NOP_INSTR`, 32'h00000013: encoding excluded from `instr_count`.
- `LOOP1_THRESH`, 3: consecutive single-instruction matches required.
- `LOOP2_THRESH`, 4: consecutive 2-cycle matches required.
- `LOOP3_THRESH`, 6: consecutive 3-cycle matches required.
- `LOOP4_THRESH`, 8: consecutive 4-cycle matches required.

Ports:
- `clock`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: one-cycle pulse; accepted in IDLE or DONE.
- `pc_current`, in, 32: core fetch PC.
- `instruction_current`, in, 32: core current instruction.
- `stall`, in, 1: core hazard stall.
- `a0_value`, in, 32: core register x10.
- `core_reset`, out, 1: reset to `datapath`.
- `running`, out, 1: high in RUN.
- `done`, out, 1: high in DONE.
- `halt_kind`, out, 3: 0 none, 1–4 loop length, 7 timeout.
- `cycle_count`, out, 32: RUN cycles.
- `instr_count`, out, 32: counted instructions.
- `final_pc`, out, 32: PC on the detection cycle.
- `result`, out, 32: `a0_value` captured on the detection cycle.

## Operation
- FSM states are IDLE, HOLD, RUN and DONE.
- IDLE → HOLD on `start`. HOLD → RUN after `RESET_CYCLES` cycles. RUN → DONE on detect or timeout. DONE → HOLD on `start`.
- `start` in HOLD or RUN is ignored.
- `core_reset` = 1 in IDLE, HOLD and DONE; 0 only in RUN.
- On entry to HOLD, clear all counters, history, match counters, `halt_kind`, `final_pc` and `result`.
- Each RUN cycle:
  - `cycle_count` +1.
  - `instr_count` +1 if `instruction_current != NOP_INSTR` and `!stall`.
  - Both counters saturate at 32'hFFFFFFFF.
- History is a 4-entry shift register of past PCs; `hist[k-1]` holds the PC from k cycles ago. `prev_instr` holds the previous instruction.
- `hvalid` counts RUN cycles seen, saturating at 4. Match-k is evaluated only when `hvalid >= k`.
- Match-1: `pc_current == hist[0]` and `instruction_current == prev_instr`.
- Match-k (k = 2..4): `pc_current == hist[k-1]`.
- Each match counter increments on a hit and clears to 0 on a miss. The counters are 4 bits and saturate.
- Loop-k is detected in the cycle where match-k counter + 1 ≥ `LOOPk_THRESH` on a hit.
- If several loops are detected together, the lowest k wins.
- Timeout fires when `cycle_count + 1 == TIMEOUT_CYCLES` in RUN; it gives `halt_kind` = 7. A loop detect in the same cycle takes priority over timeout.
- On the detect cycle, latch `final_pc = pc_current`, `result = a0_value` and `halt_kind`, then go to DONE.
- Outputs hold in DONE until the next `start`.

## Timing
- Reset values:
  - FSM state = IDLE.
  - `core_reset` = 1.
  - `running` = 0, `done` = 0.
  - `halt_kind` = 0.
  - All 32-bit outputs = 0.
- `start` at edge N puts the FSM in HOLD from N+1. RUN begins at N+1+`RESET_CYCLES`, and `core_reset` falls in the same cycle.
- Detect at edge M gives `done` = 1 and `core_reset` = 1 from M+1. `cycle_count` includes the detect cycle.
- `reset` mid-RUN returns to IDLE on the next edge and clears all state; `core_reset` is asserted immediately.
- All outputs are registered.

## Configuration
- `RUN_CTRL_MULTI_LOOP_EN` defined: Match-2/3/4 logic, the PC history and `halt_kind` values 2–4 are built.
- Undefined: only Match-1 and timeout exist. History collapses to `hist[0]`, so `halt_kind` ∈ {0, 1, 7}.

## Structure
- Package `cpu_run_ctrl_pkg`:
  - State enum.
  - `halt_kind` encodings: HK_NONE, HK_L1..HK_L4, HK_TIMEOUT.
  - Default NOP constant.
- One sub-module, `pc_loop_detector`. It holds the history, match counters and priority encoder, and outputs `detect` and `kind`. The top level holds the FSM, counters and capture registers.

## Test plan
- Straight-line then `j .`:
  - Stimulus: PCs 0,4,…,0x28, then 0x28 repeated with the same instruction.
  - Response: `halt_kind` = 1, `final_pc` = 0x28, `done` rises 3 cycles after the first repeat.
- 2-loop:
  - Stimulus: PCs alternate 0x30/0x34.
  - Response: `halt_kind` = 2 after 4 consecutive hits.
- 4-loop with the feature off:
  - Stimulus: PCs cycle 0x40–0x4C, with no timeout before the check.
  - Response: no detection; timeout after 2000 RUN cycles gives `halt_kind` = 7 and `cycle_count` = 2000.
- Counting:
  - Stimulus: 10 RUN cycles containing 3 NOPs and 2 stalled cycles.
  - Response: `instr_count` = 5, `cycle_count` = 10.
- Reset mid-RUN:
  - Stimulus: assert `reset` for 1 cycle during RUN, then `start`.
  - Response: IDLE with cleared outputs and `core_reset` = 1; counters start again from 0.
- Start ignored:
  - Stimulus: `start` during RUN.
  - Response: no effect. A later `start` in DONE re-enters HOLD and `done` clears.

Source files
------------

// File: rtl/cpu_run_ctrl_pkg.sv
// cpu_run_ctrl_pkg: run-controller state enum, halt-kind encodings and default NOP
package cpu_run_ctrl_pkg;
  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_RUN, S_DONE} run_state_e;
  localparam logic [2:0] HK_NONE    = 3'd0;
  localparam logic [2:0] HK_L1      = 3'd1;
  localparam logic [2:0] HK_L2      = 3'd2;
  localparam logic [2:0] HK_L3      = 3'd3;
  localparam logic [2:0] HK_L4      = 3'd4;
  localparam logic [2:0] HK_TIMEOUT = 3'd7;
  localparam logic [31:0] NOP_DEFAULT = 32'h00000013;
endpackage

// File: rtl/cpu_run_controller_loop_detector.sv
// pc_loop_detector: PC history, loop match counters and lowest-length-first priority (loops 2-4 only with RUN_CTRL_MULTI_LOOP_EN)
module pc_loop_detector
  import cpu_run_ctrl_pkg::*;
#(
  parameter int LOOP1_THRESH = 3,
  parameter int LOOP2_THRESH = 4,
  parameter int LOOP3_THRESH = 6,
  parameter int LOOP4_THRESH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        en_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  output logic        detect_o,
  output logic [2:0]  kind_o
);
`ifdef RUN_CTRL_MULTI_LOOP_EN
  localparam int HD = 4;
`else
  localparam int HD = 1;
`endif
  localparam int THRESH [1:4] = '{LOOP1_THRESH, LOOP2_THRESH, LOOP3_THRESH, LOOP4_THRESH};
  logic [31:0] hist_q [HD];
  logic [31:0] prev_instr_q;
  logic [2:0]  hvalid_q;
  logic [3:0]  mcnt_q [1:HD];
  logic [3:0]  mcnt_d [1:HD];
  logic [HD:1] hit;
  logic [HD:1] fire;
  // evaluate each loop length against history; shortest firing loop wins
  always_comb begin
    kind_o = HK_NONE;
    for (int k = 1; k <= HD; k++) begin
      hit[k] = int'(hvalid_q) >= k && pc_i == hist_q[k-1] && (k != 1 || instr_i == prev_instr_q);
      mcnt_d[k] = hit[k] ? (mcnt_q[k] == 4'hF ? 4'hF : mcnt_q[k] + 4'd1) : 4'd0;
      fire[k] = hit[k] && int'(mcnt_q[k]) + 1 >= THRESH[k];
    end
    for (int k = HD; k >= 1; k--) kind_o = fire[k] ? 3'(k) : kind_o;
    detect_o = en_i && |fire;
  end
  // shift history and update match counters on every RUN cycle
  always_ff @(posedge clock) begin
    if (reset || clear_i) begin
      hist_q       <= '{default: '0};
      prev_instr_q <= '0;
      hvalid_q     <= '0;
      mcnt_q       <= '{default: '0};
    end else if (en_i) begin
      hist_q[0] <= pc_i;
      for (int k = 1; k < HD; k++) hist_q[k] <= hist_q[k-1];
      prev_instr_q <= instr_i;
      hvalid_q     <= hvalid_q == 3'd4 ? 3'd4 : hvalid_q + 3'd1;
      mcnt_q       <= mcnt_d;
    end
  end
endmodule

// File: rtl/cpu_run_controller.sv
// cpu_run_controller: releases the core on start, counts cycles/instructions, stops on halt loop or timeout (RUN_CTRL_MULTI_LOOP_EN enables loops 2-4)
module cpu_run_controller
  import cpu_run_ctrl_pkg::*;
#(
  parameter int          RESET_CYCLES   = 2,
  parameter int          TIMEOUT_CYCLES = 2000,
  parameter logic [31:0] NOP_INSTR      = NOP_DEFAULT,
  parameter int          LOOP1_THRESH   = 3,
  parameter int          LOOP2_THRESH   = 4,
  parameter int          LOOP3_THRESH   = 6,
  parameter int          LOOP4_THRESH   = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] pc_current,
  input  logic [31:0] instruction_current,
  input  logic        stall,
  input  logic [31:0] a0_value,
  output logic        core_reset,
  output logic        running,
  output logic        done,
  output logic [2:0]  halt_kind,
  output logic [31:0] cycle_count,
  output logic [31:0] instr_count,
  output logic [31:0] final_pc,
  output logic [31:0] result
);
  run_state_e  state_q, state_d;
  logic [31:0] hold_q, hold_d, cyc_q, cyc_d, ins_q, ins_d, fpc_q, fpc_d, res_q, res_d;
  logic [2:0]  kind_q, kind_d, det_kind;
  logic        clr, det, timeout;
  logic        core_reset_q, run_q, done_q;
  pc_loop_detector #(
    .LOOP1_THRESH(LOOP1_THRESH),
    .LOOP2_THRESH(LOOP2_THRESH),
    .LOOP3_THRESH(LOOP3_THRESH),
    .LOOP4_THRESH(LOOP4_THRESH)
  ) u_det (
    .clock   (clock),
    .reset   (reset),
    .clear_i (clr),
    .en_i    (state_q == S_RUN),
    .pc_i    (pc_current),
    .instr_i (instruction_current),
    .detect_o(det),
    .kind_o  (det_kind)
  );
  // next-state, counting and capture of the detect-cycle snapshot
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cyc_d   = cyc_q;
    ins_d   = ins_q;
    kind_d  = kind_q;
    fpc_d   = fpc_q;
    res_d   = res_q;
    clr     = 1'b0;
    timeout = cyc_q + 32'd1 == 32'(TIMEOUT_CYCLES);
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = start ? S_HOLD : state_q;
        clr     = start;
      end
      S_HOLD: begin
        hold_d  = hold_q + 32'd1;
        state_d = hold_q == 32'(RESET_CYCLES - 1) ? S_RUN : S_HOLD;
      end
      S_RUN: begin
        cyc_d = &cyc_q ? cyc_q : cyc_q + 32'd1;
        ins_d = (instruction_current != NOP_INSTR && !stall && !(&ins_q)) ? ins_q + 32'd1 : ins_q;
        if (det || timeout) begin
          state_d = S_DONE;
          kind_d  = det ? det_kind : HK_TIMEOUT;
          fpc_d   = pc_current;
          res_d   = a0_value;
        end
      end
    endcase
    if (clr) begin
      hold_d = '0;
      cyc_d  = '0;
      ins_d  = '0;
      kind_d = HK_NONE;
      fpc_d  = '0;
      res_d  = '0;
    end
  end
  // state and output registers; status flags follow the next state so they are registered
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      hold_q       <= '0;
      cyc_q        <= '0;
      ins_q        <= '0;
      kind_q       <= HK_NONE;
      fpc_q        <= '0;
      res_q        <= '0;
      core_reset_q <= 1'b1;
      run_q        <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cyc_q        <= cyc_d;
      ins_q        <= ins_d;
      kind_q       <= kind_d;
      fpc_q        <= fpc_d;
      res_q        <= res_d;
      core_reset_q <= state_d != S_RUN;
      run_q        <= state_d == S_RUN;
      done_q       <= state_d == S_DONE;
    end
  end
  assign core_reset  = core_reset_q;
  assign running     = run_q;
  assign done        = done_q;
  assign halt_kind   = kind_q;
  assign cycle_count = cyc_q;
  assign instr_count = ins_q;
  assign final_pc    = fpc_q;
  assign result      = res_q;
endmodule
